// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and access-legality helper for the MEM stage.
package mem_pkg;

  localparam logic [2:0] MEM_NONE  = 3'b000;
  localparam logic [2:0] MEM_LOAD  = 3'b001;
  localparam logic [2:0] MEM_STORE = 3'b010;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {StIdle, StBusy} mem_state_e;

  // True for an illegal width for the access direction or a misaligned half/word.
  function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic legal;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !is_store;
      default:          legal = 1'b0;
    endcase
    return !legal || (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of the read word and sign/zero extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[7:0];
    case (offset)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_BU:   result = {24'h0, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_HU:   result = {16'h0, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: bus request/ack sequencing, MMR write strobe, load alignment and MEM/WB
// register. Upstream is held by stall_out while a bus access is outstanding.
module mem_access_stage #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] NOP_INST    = mem_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] rd_data_in,
  input  logic        rd_we_in,
  input  logic [31:0] mem_addr_in,
  input  logic [2:0]  mem_flag_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] inst_in,
  input  logic        mmr_we_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mmr_we,
  output logic [31:0] mmr_addr,
  output logic [31:0] mmr_wdata,
  output logic        stall_out,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_data,
  output logic        wb_rd_we,
  output logic [31:0] wb_inst,
  output logic        mem_exc,
  output logic        bus_err
);

  import mem_pkg::*;

  localparam int unsigned CntW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

  mem_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic        is_load, is_store, is_mmr, bad, start, timeout;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_data;

  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  assign funct3   = inst_in[14:12];
  assign lane     = mem_addr_in[1:0];
  assign is_load  = (mem_flag_in == MEM_LOAD);
  assign is_store = (mem_flag_in == MEM_STORE);
  assign is_mmr   = is_store && mmr_we_in;
  assign bad      = (is_load || is_store) && !is_mmr && access_bad(is_store, funct3, lane);
  assign start    = (is_load || (is_store && !mmr_we_in)) && !bad;
  // Ack in the final cycle takes precedence over the timeout.
  assign timeout  = (state_q == StBusy) && !dmem_ack && (cnt_q == CntMax);

  always_comb begin
    be_c    = 4'hF;
    wdata_c = store_data_in;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be_c    = 4'b0001 << lane;
          wdata_c = {4{store_data_in[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << lane;
          wdata_c = {2{store_data_in[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_out = 1'b0;
    dmem_req  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          stall_out = 1'b1;
          state_d   = StBusy;
          cnt_d     = '0;
        end
      end
      StBusy: begin
        dmem_req  = 1'b1;
        stall_out = !dmem_ack && !timeout;
        if (dmem_ack || timeout) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      mmr_we     <= 1'b0;
      mmr_addr   <= '0;
      mmr_wdata  <= '0;
      wb_rd_addr <= '0;
      wb_rd_data <= '0;
      wb_rd_we   <= 1'b0;
      wb_inst    <= NOP_INST;
      mem_exc    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      mmr_we  <= 1'b0;
      mem_exc <= 1'b0;
      bus_err <= 1'b0;
      case (state_q)
        StIdle: begin
          wb_rd_addr <= rd_addr_in;
          wb_rd_data <= rd_data_in;
          if (is_mmr) begin
            mmr_we    <= 1'b1;
            mmr_addr  <= mem_addr_in;
            mmr_wdata <= store_data_in;
            wb_rd_we  <= 1'b0;
            wb_inst   <= inst_in;
          end else if (bad) begin
            mem_exc  <= 1'b1;
            wb_rd_we <= 1'b0;
            wb_inst  <= NOP_INST;
          end else if (start) begin
            dmem_we    <= is_store;
            dmem_addr  <= {mem_addr_in[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
            f3_q       <= funct3;
            off_q      <= lane;
            wb_rd_we   <= 1'b0;
            wb_inst    <= NOP_INST;
          end else begin
            wb_rd_we <= rd_we_in;
            wb_inst  <= inst_in;
          end
        end
        StBusy: begin
          // EX/MEM is frozen while busy, so the rd_* and inst inputs still describe this access.
          if (dmem_ack) begin
            wb_rd_addr <= rd_addr_in;
            wb_rd_data <= dmem_we ? rd_data_in : load_data;
            wb_rd_we   <= !dmem_we && rd_we_in;
            wb_inst    <= inst_in;
          end else begin
            bus_err  <= timeout;
            wb_rd_we <= 1'b0;
            wb_inst  <= NOP_INST;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
